// File: rtl/calc_operand_fsm.sv
// calc_operand_fsm
//   Captures two operands and an opcode from the switches on debounced enter
//   presses and computes the ALU result. OP1, OP2, result and state are handed
//   to the 7-segment display stage.
//   Optional feature macro: CALC_UNDO_EN. When it is defined, a rising edge on
//   undo steps back one state. When it is undefined, the undo port is ignored.
//   An enter held high through reset release never counts as a press. The
//   edge detectors are disarmed for the first clock after release.
module calc_operand_fsm #(
    parameter int N = 16
) (
    input  logic         CLK100MHZ,
    input  logic         rst,
    input  logic [N-1:0] SW,
    input  logic         enter,
    input  logic         undo,
    output logic [N-1:0] OP1,
    output logic [N-1:0] OP2,
    output logic [N-1:0] result,
    output logic [1:0]   state,
    output logic [1:0]   opcode,
    output logic         carry,
    output logic         result_vld
);

    typedef enum logic [1:0] {
        WAIT_OP1    = 2'd0,
        WAIT_OP2    = 2'd1,
        WAIT_OPCODE = 2'd2,
        SHOW_RESULT = 2'd3
    } state_t;

    state_t       state_r;
    logic         enter_q_r;
    logic         arm_r;
    logic         enter_evt_s;
    logic [N:0]   alu_s;

    // ALU: the MSB of the return value is the carry/borrow, and the low N bits are the result.
    function automatic logic [N:0] alu_f(input logic [N-1:0] a,
                                         input logic [N-1:0] b,
                                         input logic [1:0]   op);
        logic [N:0] r;
        case (op)
            2'b00:   r = {1'b0, a} + {1'b0, b};
            2'b01:   r = {(a < b), a - b};
            2'b10:   r = {1'b0, a | b};
            2'b11:   r = {1'b0, a & b};
            default: r = {(N+1){1'b0}};
        endcase
        return r;
    endfunction

    assign enter_evt_s = enter & ~enter_q_r & arm_r;
    assign alu_s       = alu_f(OP1, OP2, SW[1:0]);
    assign state       = state_r;

`ifdef CALC_UNDO_EN
    logic undo_q_r;
    logic undo_evt_s;

    assign undo_evt_s = undo & ~undo_q_r & arm_r;

    // Undo edge-detect history.
    always_ff @(posedge CLK100MHZ or posedge rst) begin
        if (rst) begin
            undo_q_r <= 1'b0;
        end else begin
            undo_q_r <= undo;
        end
    end
`else
    logic unused_undo_s;

    assign unused_undo_s = undo;
`endif

    // Enter edge-detect history, plus the arm flag that blocks the first cycle after reset release.
    always_ff @(posedge CLK100MHZ or posedge rst) begin
        if (rst) begin
            enter_q_r <= 1'b0;
            arm_r     <= 1'b0;
        end else begin
            enter_q_r <= enter;
            arm_r     <= 1'b1;
        end
    end

    // Operand/opcode capture FSM with registered outputs.
    always_ff @(posedge CLK100MHZ or posedge rst) begin
        if (rst) begin
            state_r    <= WAIT_OP1;
            OP1        <= {N{1'b0}};
            OP2        <= {N{1'b0}};
            result     <= {N{1'b0}};
            opcode     <= 2'b00;
            carry      <= 1'b0;
            result_vld <= 1'b0;
        end else if (enter_evt_s) begin
            case (state_r)
                WAIT_OP1: begin
                    OP1     <= SW;
                    state_r <= WAIT_OP2;
                end
                WAIT_OP2: begin
                    OP2     <= SW;
                    state_r <= WAIT_OPCODE;
                end
                WAIT_OPCODE: begin
                    opcode     <= SW[1:0];
                    result     <= alu_s[N-1:0];
                    carry      <= alu_s[N];
                    result_vld <= 1'b1;
                    state_r    <= SHOW_RESULT;
                end
                SHOW_RESULT: begin
                    OP1        <= {N{1'b0}};
                    OP2        <= {N{1'b0}};
                    result     <= {N{1'b0}};
                    opcode     <= 2'b00;
                    carry      <= 1'b0;
                    result_vld <= 1'b0;
                    state_r    <= WAIT_OP1;
                end
                default: begin
                    OP1        <= {N{1'b0}};
                    OP2        <= {N{1'b0}};
                    result     <= {N{1'b0}};
                    opcode     <= 2'b00;
                    carry      <= 1'b0;
                    result_vld <= 1'b0;
                    state_r    <= WAIT_OP1;
                end
            endcase
`ifdef CALC_UNDO_EN
        end else if (undo_evt_s) begin
            case (state_r)
                WAIT_OP1: begin
                    state_r <= WAIT_OP1;
                end
                WAIT_OP2: begin
                    OP1     <= {N{1'b0}};
                    state_r <= WAIT_OP1;
                end
                WAIT_OPCODE: begin
                    OP2     <= {N{1'b0}};
                    state_r <= WAIT_OP2;
                end
                SHOW_RESULT: begin
                    result     <= {N{1'b0}};
                    carry      <= 1'b0;
                    opcode     <= 2'b00;
                    result_vld <= 1'b0;
                    state_r    <= WAIT_OPCODE;
                end
                default: begin
                    state_r <= WAIT_OP1;
                end
            endcase
`endif
        end else begin
            state_r <= state_r;
        end
    end

endmodule

// File: tb/tb_calc_operand_fsm.sv
// tb_calc_operand_fsm
//   Randomized and directed bench for calc_operand_fsm. A behavioural model
//   tracks the operand/opcode entry sequence with plain integer arithmetic.
module tb_calc_operand_fsm;

    logic        clk = 1'b0;
    logic        rst;
    logic [15:0] SW;
    logic        enter;
    logic        undo;
    logic [15:0] OP1, OP2, result;
    logic [1:0]  state, opcode;
    logic        carry, result_vld;

    int tests_run    = 0;
    int tests_failed = 0;

    // Behavioural model
    int          m_stage;
    logic [15:0] m_op1, m_op2, m_res;
    logic [1:0]  m_opc;
    logic        m_carry;

    calc_operand_fsm #(.N(16)) dut (
        .CLK100MHZ (clk),
        .rst       (rst),
        .SW        (SW),
        .enter     (enter),
        .undo      (undo),
        .OP1       (OP1),
        .OP2       (OP2),
        .result    (result),
        .state     (state),
        .opcode    (opcode),
        .carry     (carry),
        .result_vld(result_vld)
    );

    // 100 MHz clock
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        tests_run++;
        if (got !== exp) begin
            tests_failed++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic model_reset();
        m_stage = 0; m_op1 = 16'h0; m_op2 = 16'h0; m_res = 16'h0; m_opc = 2'd0; m_carry = 1'b0;
    endtask

    task automatic model_enter(input logic [15:0] v);
        int unsigned a, b, s;
        a = m_op1; b = m_op2;
        case (m_stage)
            0: begin m_op1 = v; m_stage = 1; end
            1: begin m_op2 = v; m_stage = 2; end
            2: begin
                m_opc = v[1:0];
                case (v[1:0])
                    2'd0: begin s = a + b; m_res = 16'(s % 65536); m_carry = (s >= 65536); end
                    2'd1: begin m_res = 16'((a + 65536 - b) % 65536); m_carry = (a < b); end
                    2'd2: begin m_res = m_op1 | m_op2; m_carry = 1'b0; end
                    default: begin m_res = m_op1 & m_op2; m_carry = 1'b0; end
                endcase
                m_stage = 3;
            end
            default: model_reset();
        endcase
    endtask

    task automatic model_undo();
        case (m_stage)
            1: begin m_op1 = 16'h0; m_stage = 0; end
            2: begin m_op2 = 16'h0; m_stage = 1; end
            3: begin m_res = 16'h0; m_carry = 1'b0; m_opc = 2'd0; m_stage = 2; end
            default: m_stage = 0;
        endcase
    endtask

    task automatic check_all(input string where);
        check_eq({where, ".state"},      32'(state),      32'(m_stage));
        check_eq({where, ".OP1"},        32'(OP1),        32'(m_op1));
        check_eq({where, ".OP2"},        32'(OP2),        32'(m_op2));
        check_eq({where, ".result"},     32'(result),     32'(m_res));
        check_eq({where, ".opcode"},     32'(opcode),     32'(m_opc));
        check_eq({where, ".carry"},      32'(carry),      32'(m_carry));
        check_eq({where, ".result_vld"}, 32'(result_vld), 32'(m_stage == 3));
    endtask

    // Press enter with value v, hold it for 'hold' extra cycles while scrambling SW, then release.
    task automatic press_enter(input logic [15:0] v, input int hold);
        SW = v; enter = 1'b1;
        tick();
        model_enter(v);
        check_all("press");
        for (int i = 0; i < hold; i++) begin
            SW = 16'($urandom);
`ifndef CALC_UNDO_EN
            undo = 1'($urandom_range(0, 1));
`endif
            tick();
            check_all("hold");
        end
        enter = 1'b0; SW = 16'($urandom);
        tick();
        check_all("release");
    endtask

    task automatic go_idle();
        for (int i = 0; i < 4; i++) begin
            if (m_stage != 0) press_enter(16'($urandom), 0);
        end
    endtask

    initial begin
        rst = 1'b1; SW = 16'h0; enter = 1'b0; undo = 1'b0;
        model_reset();
        repeat (3) tick();
        check_all("reset");
        rst = 1'b0;
        tick();
        check_all("post_reset");

        // Basic add sequence then clear
        press_enter(16'h0003, 0);
        check_eq("t1.state1", 32'(state), 32'd1);
        press_enter(16'h0005, 1);
        check_eq("t1.state2", 32'(state), 32'd2);
        press_enter(16'h0000, 2);
        check_eq("t1.result", 32'(result), 32'h0008);
        check_eq("t1.carry",  32'(carry),  32'd0);
        check_eq("t1.state3", 32'(state),  32'd3);
        press_enter(16'h1234, 0);
        check_eq("t1.state0", 32'(state),  32'd0);
        check_eq("t1.OP1clr", 32'(OP1),    32'd0);

        // Add/sub wrap
        press_enter(16'hFFFF, 0); press_enter(16'h0001, 0); press_enter(16'h0000, 0);
        check_eq("t2.add_res", 32'(result), 32'h0000);
        check_eq("t2.add_c",   32'(carry),  32'd1);
        press_enter(16'h0000, 0);
        press_enter(16'h0000, 0); press_enter(16'h0001, 0); press_enter(16'hABCD, 0);
        check_eq("t2.sub_res", 32'(result), 32'hFFFF);
        check_eq("t2.sub_c",   32'(carry),  32'd1);
        press_enter(16'h0000, 0);

        // Logic ops
        press_enter(16'hF0F0, 0); press_enter(16'h0FF0, 0); press_enter(16'h0002, 0);
        check_eq("t3.or_res", 32'(result), 32'hFFF0);
        check_eq("t3.or_c",   32'(carry),  32'd0);
        press_enter(16'h0000, 0);
        press_enter(16'hF0F0, 0); press_enter(16'h0FF0, 0); press_enter(16'h0003, 0);
        check_eq("t3.and_res", 32'(result), 32'h00F0);
        check_eq("t3.and_c",   32'(carry),  32'd0);
        press_enter(16'h0000, 0);

        // Long hold: exactly one event
        press_enter(16'h5A5A, 1000);
        check_eq("t4.state", 32'(state), 32'd1);
        check_eq("t4.OP1",   32'(OP1),   32'h5A5A);
        go_idle();

        // Async reset mid-sequence, enter high across release
        press_enter(16'h1234, 0); press_enter(16'h4321, 0);
        #2;
        rst = 1'b1;
        #1;
        model_reset();
        check_eq("t5.state_async", 32'(state), 32'd0);
        check_eq("t5.OP1_async",   32'(OP1),   32'd0);
        enter = 1'b1; SW = 16'h7777;
        tick(); tick();
        rst = 1'b0;
        for (int i = 0; i < 5; i++) begin
            tick();
            check_all("t5.held");
        end
        enter = 1'b0;
        tick();
        check_all("t5.fall");
        press_enter(16'h7777, 0);
        check_eq("t5.rise_state", 32'(state), 32'd1);
        go_idle();

`ifdef CALC_UNDO_EN
        // Undo from SHOW_RESULT, then enter and undo together
        press_enter(16'h0010, 0); press_enter(16'h0020, 0); press_enter(16'h0000, 0);
        undo = 1'b1;
        tick();
        model_undo();
        check_eq("t6.undo_state", 32'(state),  32'd2);
        check_eq("t6.undo_res",   32'(result), 32'd0);
        undo = 1'b0;
        tick();
        SW = 16'h0001; enter = 1'b1; undo = 1'b1;
        tick();
        model_enter(16'h0001);
        check_eq("t6.both_state", 32'(state),  32'd3);
        check_eq("t6.both_res",   32'(result), 32'hFFF0);
        check_all("t6.both");
        enter = 1'b0; undo = 1'b0;
        tick();
        go_idle();
`endif

        // Randomized sequence
        for (int n = 0; n < 200; n++) begin
`ifdef CALC_UNDO_EN
            if ($urandom_range(0, 3) == 0) begin
                undo = 1'b1;
                tick();
                model_undo();
                check_all("rnd.undo");
                undo = 1'b0;
                tick();
                check_all("rnd.undo_rel");
            end else begin
                press_enter(16'($urandom), int'($urandom_range(0, 3)));
            end
`else
            press_enter(16'($urandom), int'($urandom_range(0, 3)));
`endif
        end

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
